// File: rtl/divider_32bit.sv
// Sequential restoring shift-subtract divider for the DIV/DIVU path.
// One quotient bit is resolved per clock; signed operands are divided as
// magnitudes and the signs are reapplied when the result is loaded.
module divider_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] q;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvsr_mag;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             last_iter;
    logic             dvnd_neg;
    logic             dvsr_neg;
    logic             dvsr_zero;
    logic [WIDTH-1:0] dvnd_abs;
    logic [WIDTH-1:0] dvsr_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    // A new request is taken in IDLE or DONE; start during RUN is ignored.
    assign accept    = start && (state != RUN);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign dvsr_zero = (divisor == '0);

    // In signed mode a negative operand is negated; the most negative value
    // maps onto its own bit pattern, which is the correct unsigned magnitude.
    assign dvnd_neg = signed_op & dividend[WIDTH-1];
    assign dvsr_neg = signed_op & divisor[WIDTH-1];
    assign dvnd_abs = dvnd_neg ? (~dividend + 1'b1) : dividend;
    assign dvsr_abs = dvsr_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step: shift {rem, q} left, try to subtract the divisor.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
        rem_sh   = {rem, q[WIDTH-1]};
        trial    = rem_sh - {1'b0, dvsr_mag};
        rem_step = rem_sh[WIDTH-1:0];
        q_step   = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            q_step   = {q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state logic for the IDLE / RUN / DONE sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = dvsr_zero ? DONE : RUN;
            end
            RUN: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                if (accept) state_nxt = dvsr_zero ? DONE : RUN;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            q           <= '0;
            dvsr_mag    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvsr_mag <= dvsr_abs;
            neg_q    <= dvnd_neg ^ dvsr_neg;
            neg_r    <= dvnd_neg;
            cnt      <= '0;
            rem      <= '0;
            q        <= dvnd_abs;
            if (dvsr_zero) begin
                // Division by zero completes immediately with fixed results.
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem <= rem_step;
            q   <= q_step;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                quotient    <= neg_q ? (~q_step + 1'b1) : q_step;
                remainder   <= neg_r ? (~rem_step + 1'b1) : rem_step;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: the driver pushes the reference result
// for each accepted request, the monitor pops and compares on every done.
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    divider_32bit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division in a wide signed domain, which
    // truncates toward zero and gives the remainder the dividend's sign.
    function automatic exp_t ref_div(input logic sop, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sd, qq, rr;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sop) begin
            sa    = longint'($signed(a));
            sd    = longint'($signed(b));
            qq    = sa / sd;
            rr    = sa % sd;
            e.q   = qq[31:0];
            e.r   = rr[31:0];
            e.dbz = 1'b0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h/%h expected=none", quotient, remainder);
            end else begin
                mon_e = sbq.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
            end
        end
    end

    // Issue one request at the current falling edge and wait for its done.
    // poke_at > 0 fires a second start with other operands while running.
    task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        sbq.push_back(ref_div(sop, a, b));
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        busy_cnt  = 0;
        seen      = 1'b0;
        lat       = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start     = 1'b0;
                dividend  = $urandom;
                divisor   = $urandom;
                signed_op = 1'($urandom_range(0, 1));
            end
            if (poke_at > 0 && k == poke_at) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(1, 100);
            end
            if (poke_at > 0 && k == poke_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", tag);
            sbq.delete();
        end else begin
            check({tag, "_latency"}, lat, (b == 32'd0) ? 32'd1 : 32'd33);
            check({tag, "_busy_cycles"}, busy_cnt, (b == 32'd0) ? 32'd0 : 32'd32);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;

        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        #2;
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back-to-back out of the DONE cycle.
        run_op(1'b0, 32'd100,       32'd7,         0, "u100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "s_m7_2");
        run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, "s_7_m2");
        run_op(1'b0, 32'h1234_5678, 32'd0,         0, "u_dbz");
        run_op(1'b1, 32'h1234_5678, 32'd0,         0, "s_dbz");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1,         0, "u_max_1");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
        run_op(1'b0, 32'd5,         32'd9,         0, "u5_9");

        // From IDLE, with a second start at E10 that must be ignored.
        @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, 10, "ignore_start");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        signed_op = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_quotient", quotient, 32'd0);
        check("mid_rst_remainder", remainder, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, 0, "post_rst");

        // Randomized signed/unsigned pairs with emphasis on small and zero divisors.
        for (int i = 0; i < 1000; i++) begin
            sop = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                3:       b = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                default: b = 32'($urandom_range(0, 3));
            endcase
            run_op(sop, a, b, 0, "rand");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
